sa_share_arbiter: RTL
=====================

Name: sa_share_arbiter

Overview:
- Shares one SA_wrapper systolic array between N_REQ matrix-multiply requesters, for example several attention heads or a Q·Kᵀ engine and an S·V engine.
- Arbitration is round-robin. Each job holds the grant from clear, through start, until SA valid.
- The SA sideband (clear, start, operand matrices) is driven from the granted requester only.
- The SA result, PE-shift and a done pulse are returned to the granted requester only.
- Sits between attention-level controllers and SA_wrapper.

Parameters:
- D_W, 16, element width in bits.
- SA_R, 16, SA rows.
- SA_C, 16, SA columns.
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, maximum cycles in WAIT before the job is aborted.

Ports:
- I_CLK  in  1  clock.
- I_ASYN_RSTN  in  1  asynchronous active-low reset.
- I_SYNC_RSTN  in  1  synchronous active-low soft reset.
- I_REQ  in  N_REQ  per-requester level request; held until O_DONE/O_ERR.
- I_MAT_1  in  N_REQ*SA_R*SA_C*D_W  packed left operands, one slice per requester; stable while requesting.
- I_MAT_2  in  N_REQ*SA_R*SA_C*D_W  packed right/weight operands, one slice per requester.
- O_GNT  out  N_REQ  one-hot grant (registered).
- O_DONE  out  N_REQ  one-cycle pulse, job complete.
- O_ERR  out  N_REQ  one-cycle pulse, job timed out.
- O_PE_SHIFT  out  N_REQ  I_PE_SHIFT routed to the granted requester; 0 elsewhere.
- O_RESULT  out  SA_R*SA_C*D_W  registered SA result, valid with O_DONE.
- O_SA_CLEARN  out  1  to SA_wrapper I_SYNC_RSTN.
- O_SA_START  out  1  to SA_wrapper I_START_FLAG.
- O_MAT_1  out  SA_R*SA_C*D_W  to SA_wrapper I_X_MATRIX.
- O_MAT_2  out  SA_R*SA_C*D_W  to SA_wrapper I_W_MATRIX.
- I_SA_VLD  in  1  from SA_wrapper O_OUT_VLD.
- I_PE_SHIFT  in  1  from SA_wrapper O_PE_SHIFT.
- I_SA_RESULT  in  SA_R*SA_C*D_W  from SA_wrapper O_OUT.

Behaviour:
- Clock and reset: one clock, I_CLK. Reset I_ASYN_RSTN is asynchronous and active-low.
- Reset values (I_ASYN_RSTN=0, or I_SYNC_RSTN=0 at a clock edge):
  - state IDLE, RR pointer 0, O_GNT 0.
  - O_DONE 0, O_ERR 0, O_SA_START 0, O_SA_CLEARN 1.
  - O_RESULT 0, timeout counter 0.
- States: IDLE → CLR → START → WAIT → RESP → IDLE.
- IDLE:
  - If I_REQ≠0, select the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Register O_GNT one-hot and go to CLR.
  - Otherwise stay in IDLE.
- CLR: O_SA_CLEARN=0 for exactly 1 cycle; go to START.
- START: O_SA_START=1 for exactly 1 cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On I_SA_VLD=1: capture I_SA_RESULT into O_RESULT and go to RESP.
  - If the counter reaches TIMEOUT−1 without I_SA_VLD: pulse O_ERR[gnt] next cycle, drive one CLR cycle on the SA, then return to IDLE.
  - If I_SA_VLD and the timeout coincide, I_SA_VLD wins.
- RESP:
  - O_DONE[gnt]=1 for 1 cycle; O_RESULT holds until the next capture.
  - Pointer = index(gnt)+1 mod N_REQ; O_GNT cleared; go to IDLE.
- O_MAT_1/O_MAT_2 are a combinational mux of the granted slice when O_GNT≠0, and 0 when idle.
- O_PE_SHIFT = I_PE_SHIFT replicated and ANDed with O_GNT.
- Latency: I_REQ seen in IDLE at edge t gives O_SA_CLEARN low in cycle t+1, O_SA_START in t+2, O_DONE one cycle after I_SA_VLD.
- Back-to-back: minimum 1 IDLE cycle between jobs. A requester that keeps I_REQ high after O_DONE is treated as a new request.
- Request deassertion mid-job is ignored: the job completes and O_DONE still pulses.
- I_SA_VLD outside WAIT is ignored.
- Soft reset mid-job aborts immediately with no O_DONE/O_ERR. The next job always begins with CLR, so the SA array is re-cleared.

Decomposition:
- Package sa_arb_pkg holds:
  - state enum (IDLE, CLR, START, WAIT, RESP).
  - localparam MAT_W = SA_R*SA_C*D_W.
  - function clog2-based index width.
- Sub-module rr_arbiter (N_REQ) contains the combinational round-robin pick given req and pointer, returning one-hot and index. It is also reusable elsewhere.

Test Plan:
- Single requester: N_REQ=4, I_REQ=4'b0010, SA model asserts VLD 40 cycles after START.
  - Required: O_GNT=0010; CLEARN low in cycle 1; START in cycle 2; O_DONE=0010 at cycle 43; O_RESULT equals the model result.
- All request: I_REQ=1111 held.
  - Required: grant order 0,1,2,3,0.
  - Required: each O_DONE matches its own operands (requester i matrices filled with i·16'h100).
- Pointer fairness: requester 0 re-requests immediately after done while requester 2 waits.
  - Required: requester 2 is granted before requester 0's second job.
- Timeout: TIMEOUT=64, SA never asserts VLD.
  - Required: O_ERR[gnt] pulses 64 cycles after START.
  - Required: one CLEARN-low cycle follows, then IDLE; no O_DONE.
- Soft reset: I_SYNC_RSTN=0 for 1 cycle during WAIT.
  - Required: next cycle O_GNT=0, state IDLE, no DONE/ERR.
  - Required: a late I_SA_VLD is ignored; the pointer is 0 afterwards.
- Async reset mid-START: assert I_ASYN_RSTN low between edges.
  - Required: O_SA_START=0 and O_SA_CLEARN=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sa_arb_pkg.sv
// Shared types and helpers for the systolic-array share arbiter.
package sa_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_START,
        ST_WAIT,
        ST_RESP,
        ST_ERR,
        ST_FLUSH
    } arb_state_t;

    localparam int unsigned D_W_DEF  = 16;
    localparam int unsigned SA_R_DEF = 16;
    localparam int unsigned SA_C_DEF = 16;
    localparam int unsigned MAT_W    = SA_R_DEF * SA_C_DEF * D_W_DEF;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import sa_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [IW-1:0] k;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = IW'((32'(ptr) + i) % N_REQ);
            if (!gnt_any && req[k]) begin
                gnt_any   = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_idx   = k;
            end
        end
    end

endmodule

// File: rtl/sa_share_arbiter.sv
// Round-robin sharing of one systolic array between N_REQ requesters.
// Each job owns the array from the clear pulse through the result handback.
module sa_share_arbiter
    import sa_arb_pkg::*;
#(
    parameter int unsigned D_W     = 16,
    parameter int unsigned SA_R    = 16,
    parameter int unsigned SA_C    = 16,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                           I_CLK,
    input  logic                           I_ASYN_RSTN,
    input  logic                           I_SYNC_RSTN,
    input  logic [N_REQ-1:0]               I_REQ,
    input  logic [N_REQ*SA_R*SA_C*D_W-1:0] I_MAT_1,
    input  logic [N_REQ*SA_R*SA_C*D_W-1:0] I_MAT_2,
    output logic [N_REQ-1:0]               O_GNT,
    output logic [N_REQ-1:0]               O_DONE,
    output logic [N_REQ-1:0]               O_ERR,
    output logic [N_REQ-1:0]               O_PE_SHIFT,
    output logic [SA_R*SA_C*D_W-1:0]       O_RESULT,
    output logic                           O_SA_CLEARN,
    output logic                           O_SA_START,
    output logic [SA_R*SA_C*D_W-1:0]       O_MAT_1,
    output logic [SA_R*SA_C*D_W-1:0]       O_MAT_2,
    input  logic                           I_SA_VLD,
    input  logic                           I_PE_SHIFT,
    input  logic [SA_R*SA_C*D_W-1:0]       I_SA_RESULT
);

    localparam int unsigned MW = SA_R * SA_C * D_W;
    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [MW-1:0]     result_q;
    logic              cap_en;
    logic [IW-1:0]     next_ptr;

    logic [N_REQ-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic [MW-1:0]     slice_1 [N_REQ];
    logic [MW-1:0]     slice_2 [N_REQ];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req     (I_REQ),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slice_1[g] = I_MAT_1[g*MW +: MW];
        assign slice_2[g] = I_MAT_2[g*MW +: MW];
    end

    always_comb begin
        next_ptr = (gnt_idx_q == IW'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    end

    // Timeout decision is taken when the counter steps onto TIMEOUT-1, so the
    // error pulse lands TIMEOUT cycles after the start pulse.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cap_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d     = pick_oh;
                    gnt_idx_d = pick_idx;
                    state_d   = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (I_SA_VLD) begin
                    cap_en  = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: begin
                ptr_d   = next_ptr;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                ptr_d   = next_ptr;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (!I_SYNC_RSTN) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            if (cap_en) begin
                result_q <= I_SA_RESULT;
            end
        end
    end

    always_comb begin
        O_GNT       = gnt_q;
        O_DONE      = (state_q == ST_RESP) ? gnt_q : '0;
        O_ERR       = (state_q == ST_ERR)  ? gnt_q : '0;
        O_SA_START  = (state_q == ST_START);
        O_SA_CLEARN = !((state_q == ST_CLR) || (state_q == ST_FLUSH));
        O_RESULT    = result_q;
        O_PE_SHIFT  = {N_REQ{I_PE_SHIFT}} & gnt_q;
        O_MAT_1     = (gnt_q != '0) ? slice_1[gnt_idx_q] : '0;
        O_MAT_2     = (gnt_q != '0) ? slice_2[gnt_idx_q] : '0;
    end

endmodule
